reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for three register-write requesters
// (ADMA, command and data engines) sharing a single register-bank write port.
// A winner's offset and data are latched and strobed with reg_enb until
// reg_ack arrives. The arbiter then waits for reg_ack to fall before it
// issues the next write.
// Optional feature: define REG_ARB_TIMEOUT_EN to abort a write that sees
// no reg_ack within TIMEOUT_CYCLES cycles and pulse err. With the macro
// undefined, BUSY waits indefinitely and err is tied low.
module reg_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_addr,
  input  logic [47:0] req_data,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic        reg_enb,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_data,
  input  logic        reg_ack
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("reg_write_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  logic [1:0]  state;
  logic [1:0]  last;      // index of the most recently completed requester
  logic [1:0]  owner;     // index of the requester holding the port
  logic [1:0]  win_idx;
  logic [7:0]  win_addr;
  logic [15:0] win_data;
  logic        timeout_hit;

  // Round-robin pick starting after the last served requester, plus its payload
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    win_idx  = 2'd0;
    win_addr = req_addr[7:0];
    win_data = req_data[15:0];
    case (last)
      2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    case (win_idx)
      2'd1: begin
        win_addr = req_addr[15:8];
        win_data = req_data[31:16];
      end
      2'd2: begin
        win_addr = req_addr[23:16];
        win_data = req_data[47:32];
      end
      default: ;
    endcase
  end

`ifdef REG_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Timeout counter: zero outside BUSY so it starts cleared on every issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_BUSY) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // The edge that completes the TIMEOUT_CYCLES-th BUSY cycle aborts the write
  assign timeout_hit = (state == ST_BUSY) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Error pulse to the owner on abort; a simultaneous ack takes precedence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      err <= '0;
      if (timeout_hit && !reg_ack) begin
        err <= grant;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  // Arbitration FSM: issue from IDLE, hold in BUSY, wait for ack low in RELEASE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= 2'd2;
      owner    <= 2'd0;
      grant    <= '0;
      done     <= '0;
      reg_enb  <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            owner    <= win_idx;
            grant    <= 3'b001 << win_idx;
            reg_addr <= win_addr;
            reg_data <= win_data;
            reg_enb  <= 1'b1;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (reg_ack) begin
            done    <= grant;
            grant   <= '0;
            reg_enb <= 1'b0;
            last    <= owner;
            state   <= ST_RELEASE;
          end else if (timeout_hit) begin
            grant   <= '0;
            reg_enb <= 1'b0;
            last    <= owner;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!reg_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
